mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access/write-back stage of the 5-stage MIPS pipeline; sits downstream of EX.
- Consumes the decode controls produced by ID (if_reg_write, if_mem_read, if_mem_write, op, data_write_reg) as carried through EX.
- Performs LW/LB/SW/SB through a req/ack data-memory port and stalls the pipeline while an access is outstanding.
- Drives the ID register-file write port (reg_write, write_reg, write_data), which is also ID's forwarding source.

Parameters:
ALLOW_R0_WRITE, 0, 1 = pass writes to register 0 through; 0 = suppress them (reg_write forced low when write_reg == 0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
valid_i  input  1  EX presents an instruction this cycle
if_reg_write_i  input  1  ID control: load write-back
if_mem_read_i  input  1  ID control: memory read (LW/LB)
if_mem_write_i  input  1  ID control: memory write (SW/SB)
op_i  input  6  opcode ins[31:26]
alu_result_i  input  32  ALU result, effective address, or JAL link value
store_data_i  input  32  rt value for stores
data_write_reg_i  input  5  destination register
stall_o  output  1  hold EX/ID/IF; upstream keeps all *_i stable while high
mem_req  output  1  data-memory request
mem_we  output  1  1 = write
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_be  output  4  byte enables, little-endian
mem_wdata  output  32  store data
mem_rdata  input  32  read data, valid when mem_ack = 1
mem_ack  input  1  access done; sampled only while mem_req = 1
reg_write  output  1  register-file write enable, to ID
write_reg  output  5  destination register, to ID
write_data  output  32  write data, to ID

Behaviour:
- Reset values:
  - FSM state = IDLE.
  - mem_req, mem_we, reg_write, stall_o = 0.
  - mem_addr, mem_be, mem_wdata, write_reg, write_data = 0.
- FSM has two states, IDLE and ACCESS. stall_o = (state == ACCESS).
- IDLE, valid_i = 1, with neither if_mem_read_i nor if_mem_write_i set:
  - Write-enable WE = if_reg_write_i OR op_i in {000000, 001000, 001001, 001100, 001101, 001110, 001111, 000011}.
  - Next cycle: reg_write = WE, write_reg = data_write_reg_i, write_data = alu_result_i. This is 1-cycle latency; reg_write is a single-cycle pulse.
- IDLE, valid_i = 1, with if_mem_read_i or if_mem_write_i set:
  - Register the access and go to ACCESS.
  - Next cycle: mem_req = 1, mem_we = if_mem_write_i.
  - mem_addr = {alu_result_i[31:2], 2'b00}; low address bits on LW/SW are ignored (no alignment exception).
- Byte-enable and store-data encoding:
  - LW/SW: mem_be = 1111, mem_wdata = store_data_i.
  - LB/SB: mem_be = 0001 << addr[1:0]; SB mem_wdata = store_data_i[7:0] replicated into all 4 byte lanes.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata are held constant until mem_ack is sampled high.
  - valid_i is ignored.
  - On the ack edge: go to IDLE. mem_req = 0 and stall_o = 0 from the next cycle.
- Load write-back, in the cycle after the ack:
  - reg_write = 1, write_reg = the captured rt.
  - LW: write_data = mem_rdata.
  - LB: write_data = sign-extended byte addr[1:0] of mem_rdata (lane 0 = bits 7:0).
  - Total load latency = 1 + ack wait + 1 cycles.
- Stores produce no write-back; reg_write stays 0.
- Register 0: with ALLOW_R0_WRITE = 0, any write-back to register 0 gives reg_write = 0. write_reg and write_data still update.
- mem_ack while mem_req = 0 is ignored.
- Zero-wait memory (ack in the first ACCESS cycle) gives exactly 1 ACCESS cycle.
- rst asserted mid-access: the access is abandoned immediately and asynchronously (mem_req drops, no write-back); the FSM returns to IDLE.
- valid_i = 0 in IDLE: no state change; reg_write = 0 next cycle.
- Back-to-back ALU ops: one write-back per cycle, no stall.

Test Plan:
- ADDIU: op 001001, alu_result 0x0000_0005, rd 8, valid 1 cycle -> next cycle reg_write = 1, write_reg = 8, write_data = 5; one cycle after that, reg_write = 0; stall_o stays 0.
- LW: addr 0x0000_1006, ack after 3 cycles, rdata 0xDEAD_BEEF, rt 9 -> mem_addr = 0x0000_1004, be = 1111, stall_o high for 3 cycles; write_data = 0xDEAD_BEEF, write_reg = 9 one cycle after the ack.
- LB: addr 0x0000_2003, rdata 0x80AB_CDEF, zero-wait ack -> mem_be = 1000, write_data = 0xFFFF_FF80. Repeat with addr ...2001 -> write_data = 0xFFFF_FFCD.
- SB: addr 0x0000_3002, store_data 0x0000_005A -> mem_we = 1, mem_be = 0100, mem_wdata = 0x5A5A_5A5A; reg_write never asserted.
- Register 0: ADDI with rt 0 and ALLOW_R0_WRITE = 0 -> reg_write = 0. Same stimulus with ALLOW_R0_WRITE = 1 -> reg_write = 1.
- Reset mid-access: LW outstanding, rst pulsed before ack -> mem_req = 0 and stall_o = 0 immediately; a later stray mem_ack is ignored; no write-back occurs.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage of the 5-stage MIPS pipeline.
// Runs loads and stores over a req/ack port and drives the register-file write port.
module mem_wb_stage #(
  parameter bit ALLOW_R0_WRITE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        if_reg_write_i,
  input  logic        if_mem_read_i,
  input  logic        if_mem_write_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  data_write_reg_i,
  output logic        stall_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t      r_state;
  logic        r_is_load;
  logic        r_is_byte;
  logic [4:0]  r_rt;
  logic [1:0]  r_lane;

  logic        w_is_mem;
  logic        w_is_byte;
  logic        w_op_we;
  logic        w_alu_we;
  logic        w_alu_dst_ok;
  logic        w_ld_dst_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [31:0] w_load_data;

  assign stall_o   = (r_state == ACCESS);
  assign w_is_mem  = if_mem_read_i | if_mem_write_i;
  assign w_is_byte = (op_i == OP_LB) | (op_i == OP_SB);

  // Opcodes whose result always lands in the register file
  always_comb begin
    w_op_we = 1'b0;
    case (op_i)
      OP_RTYPE, OP_JAL, OP_ADDI, OP_ADDIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_op_we = 1'b1;
      default:                          w_op_we = 1'b0;
    endcase
  end

  assign w_alu_we     = if_reg_write_i | w_op_we;
  assign w_alu_dst_ok = ALLOW_R0_WRITE | (data_write_reg_i != 5'd0);
  assign w_ld_dst_ok  = ALLOW_R0_WRITE | (r_rt != 5'd0);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    if (w_is_byte) begin
      w_be    = 4'b0001 << alu_result_i[1:0];
      w_wdata = {4{store_data_i[7:0]}};
    end
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    unique case (r_lane)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
  end

  assign w_load_data = r_is_byte ? {{24{w_byte[7]}}, w_byte} : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_load  <= 1'b0;
      r_is_byte  <= 1'b0;
      r_rt       <= 5'd0;
      r_lane     <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
    end else begin
      reg_write <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (valid_i && w_is_mem) begin
            r_state   <= ACCESS;
            r_is_load <= if_mem_read_i & ~if_mem_write_i;
            r_is_byte <= w_is_byte;
            r_rt      <= data_write_reg_i;
            r_lane    <= alu_result_i[1:0];
            mem_req   <= 1'b1;
            mem_we    <= if_mem_write_i;
            mem_addr  <= {alu_result_i[31:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
          end else if (valid_i) begin
            reg_write  <= w_alu_we & w_alu_dst_ok;
            write_reg  <= data_write_reg_i;
            write_data <= alu_result_i;
          end
        end
        ACCESS: begin
          // Request fields stay frozen until the ack edge
          if (mem_ack) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (r_is_load) begin
              reg_write  <= w_ld_dst_ok;
              write_reg  <= r_rt;
              write_data <= w_load_data;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU write-back, LW/LB/SB, r0 handling, reset abort.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        if_reg_write_i;
  logic        if_mem_read_i;
  logic        if_mem_write_i;
  logic [5:0]  op_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [4:0]  data_write_reg_i;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        stall_o, mem_req, mem_we, reg_write;
  logic [31:0] mem_addr, mem_wdata, write_data;
  logic [3:0]  mem_be;
  logic [4:0]  write_reg;

  logic        u1_stall, u1_req, u1_we, u1_rw;
  logic [31:0] u1_addr, u1_wdata, u1_wd;
  logic [3:0]  u1_be;
  logic [4:0]  u1_wr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ALLOW_R0_WRITE(1'b0)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .if_reg_write_i(if_reg_write_i),
    .if_mem_read_i(if_mem_read_i),
    .if_mem_write_i(if_mem_write_i),
    .op_i(op_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i),
    .data_write_reg_i(data_write_reg_i),
    .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data)
  );

  mem_wb_stage #(.ALLOW_R0_WRITE(1'b1)) u1 (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .if_reg_write_i(if_reg_write_i),
    .if_mem_read_i(if_mem_read_i),
    .if_mem_write_i(if_mem_write_i),
    .op_i(op_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i),
    .data_write_reg_i(data_write_reg_i),
    .stall_o(u1_stall), .mem_req(u1_req), .mem_we(u1_we),
    .mem_addr(u1_addr), .mem_be(u1_be), .mem_wdata(u1_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .reg_write(u1_rw), .write_reg(u1_wr),
    .write_data(u1_wd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic rd,
                       input logic wr, input logic [5:0] op,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] dst);
    valid_i = v; if_reg_write_i = rw; if_mem_read_i = rd;
    if_mem_write_i = wr; op_i = op; alu_result_i = alu;
    store_data_i = sd; data_write_reg_i = dst;
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    #12;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rw", {31'd0, reg_write}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wd", write_data, 32'd0);
    step();
    rst = 1'b0;

    // ADDIU $8 = 5
    drive(1, 0, 0, 0, 6'b001001, 32'h5, 32'd0, 5'd8);
    step();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    chk("addiu_rw", {31'd0, reg_write}, 32'd1);
    chk("addiu_wr", {27'd0, write_reg}, 32'd8);
    chk("addiu_wd", write_data, 32'h5);
    chk("addiu_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("addiu_pulse", {31'd0, reg_write}, 32'd0);

    // back-to-back: J without ctl (no WE), then J with if_reg_write
    drive(1, 0, 0, 0, 6'b000010, 32'h11, 32'd0, 5'd3);
    step();
    chk("j_nowe", {31'd0, reg_write}, 32'd0);
    chk("j_wd", write_data, 32'h11);
    drive(1, 1, 0, 0, 6'b000010, 32'h22, 32'd0, 5'd4);
    step();
    chk("ctl_we", {31'd0, reg_write}, 32'd1);
    chk("ctl_wd", write_data, 32'h22);
    chk("b2b_stall", {31'd0, stall_o}, 32'd0);
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    step();
    chk("idle_rw", {31'd0, reg_write}, 32'd0);

    // LW $9 from 0x1006, ack in 3rd ACCESS cycle
    drive(1, 0, 1, 0, 6'b100011, 32'h1006, 32'd0, 5'd9);
    step();
    chk("lw_req", {31'd0, mem_req}, 32'd1);
    chk("lw_we", {31'd0, mem_we}, 32'd0);
    chk("lw_addr", mem_addr, 32'h1004);
    chk("lw_be", {28'd0, mem_be}, 32'hF);
    chk("lw_stall1", {31'd0, stall_o}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    mem_ack = 1'b0;
    step();
    chk("lw_stall2", {31'd0, stall_o}, 32'd1);
    chk("lw_hold", mem_addr, 32'h1004);
    step();
    chk("lw_stall3", {31'd0, stall_o}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    mem_ack = 1'b0;
    chk("lw_stall_off", {31'd0, stall_o}, 32'd0);
    chk("lw_req_off", {31'd0, mem_req}, 32'd0);
    chk("lw_rw", {31'd0, reg_write}, 32'd1);
    chk("lw_wr", {27'd0, write_reg}, 32'd9);
    chk("lw_wd", write_data, 32'hDEAD_BEEF);
    step();
    chk("lw_pulse", {31'd0, reg_write}, 32'd0);

    // LB from 0x2003, zero-wait
    drive(1, 0, 1, 0, 6'b100000, 32'h2003, 32'd0, 5'd10);
    step();
    chk("lb3_be", {28'd0, mem_be}, 32'h8);
    chk("lb3_addr", mem_addr, 32'h2000);
    mem_ack = 1'b1;
    mem_rdata = 32'h80AB_CDEF;
    step();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    mem_ack = 1'b0;
    chk("lb3_stall", {31'd0, stall_o}, 32'd0);
    chk("lb3_wd", write_data, 32'hFFFF_FF80);
    chk("lb3_wr", {27'd0, write_reg}, 32'd10);

    // LB from 0x2001
    drive(1, 0, 1, 0, 6'b100000, 32'h2001, 32'd0, 5'd11);
    step();
    chk("lb1_be", {28'd0, mem_be}, 32'h2);
    mem_ack = 1'b1;
    step();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    mem_ack = 1'b0;
    chk("lb1_wd", write_data, 32'hFFFF_FFCD);
    chk("lb1_rw", {31'd0, reg_write}, 32'd1);

    // SB 0x5A to 0x3002
    drive(1, 0, 0, 1, 6'b101000, 32'h3002, 32'h0000_005A, 5'd12);
    step();
    chk("sb_we", {31'd0, mem_we}, 32'd1);
    chk("sb_be", {28'd0, mem_be}, 32'h4);
    chk("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    chk("sb_addr", mem_addr, 32'h3000);
    chk("sb_rw0", {31'd0, reg_write}, 32'd0);
    mem_ack = 1'b1;
    step();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    mem_ack = 1'b0;
    chk("sb_rw1", {31'd0, reg_write}, 32'd0);
    chk("sb_req_off", {31'd0, mem_req}, 32'd0);
    step();
    chk("sb_rw2", {31'd0, reg_write}, 32'd0);

    // ADDI to $0 on both r0 policies
    drive(1, 0, 0, 0, 6'b001000, 32'h7, 32'd0, 5'd0);
    step();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    chk("r0_block", {31'd0, reg_write}, 32'd0);
    chk("r0_wd", write_data, 32'h7);
    chk("r0_allow", {31'd0, u1_rw}, 32'd1);

    // reset during an outstanding LW
    drive(1, 0, 1, 0, 6'b100011, 32'h4000, 32'd0, 5'd13);
    step();
    chk("ab_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ab_req_drop", {31'd0, mem_req}, 32'd0);
    chk("ab_stall_drop", {31'd0, stall_o}, 32'd0);
    drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_stall", {31'd0, stall_o}, 32'd0);
    chk("stray_rw", {31'd0, reg_write}, 32'd0);
    chk("stray_wd", write_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
